// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, grant IDs, and default widths.
package cpu_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_DONE
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Bus-transaction watchdog: counts cycles while enabled and flags the cycle in which
// the count reaches TIMEOUT_CYC.
module arb_timeout_ctr #(
  parameter int unsigned CW          = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // tc is asserted in the BUSY cycle whose increment would make the count reach TIMEOUT_CYC.
  assign tc = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch (IF) and data
// memory (MA). Contention is resolved by alternation, and the arbiter flags timed-out
// transactions.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          im_req,
  input  logic [AW-1:0] im_addr,
  output logic [DW-1:0] im_rdata,
  output logic          im_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);

  arb_state_e    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] im_rdata_q, im_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          im_ack_q, im_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          bus_err_q, bus_err_d;

  logic busy;
  logic timeout;

  assign busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

  arb_timeout_ctr #(
    .CW          (CW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .en    (busy),
    .tc    (timeout)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_be_d     = bus_be_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    im_rdata_d   = im_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    im_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    bus_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // D wins if I is idle, or if I was the last requester served.
        if (dm_req && (!im_req || last_grant_q == GRANT_I)) begin
          state_d      = ST_BUSY_D;
          last_grant_d = GRANT_D;
          bus_req_d    = 1'b1;
          bus_we_d     = dm_we;
          bus_be_d     = dm_be;
          bus_addr_d   = dm_addr;
          bus_wdata_d  = dm_wdata;
        end else if (im_req) begin
          state_d      = ST_BUSY_I;
          last_grant_d = GRANT_I;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_be_d     = BE_WORD;
          bus_addr_d   = im_addr;
          bus_wdata_d  = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (bus_ack || timeout) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          bus_err_d = !bus_ack;
          if (state_q == ST_BUSY_I) begin
            im_ack_d   = 1'b1;
            im_rdata_d = bus_ack ? bus_rdata : '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      im_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      im_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_be_q     <= bus_be_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      im_rdata_q   <= im_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      im_ack_q     <= im_ack_d;
      dm_ack_q     <= dm_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign im_rdata  = im_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign im_ack    = im_ack_q;
  assign dm_ack    = dm_ack_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter. It runs against a transaction-level
// model of grant order, latency, timeout, and returned data.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_rdata;
  logic          im_ack;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          bus_err;

  mem_port_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (TO),
    .CW          (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_rdata  (im_rdata),
    .im_ack    (im_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: was the most recent grant given to the data port?
  bit mdl_last_d = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit pick_d(input bit pi, input bit pd);
    return pd && (!pi || !mdl_last_d);
  endfunction

  // Entered on the negedge where bus_req should have just risen for the given winner;
  // returns on the negedge after DONE, with the winner's request dropped.
  task automatic serve(input bit is_d, input int w, input logic [DW-1:0] rd);
    int c;
    bit err;
    logic [DW-1:0] exp_rd;
    c   = (w < TO) ? w : TO - 1;
    err = (w >= TO);
    check_eq("bus_req_rise", bus_req, 1);
    check_eq("bus_addr", bus_addr, is_d ? dm_addr : im_addr);
    check_eq("bus_we", bus_we, is_d ? dm_we : 1'b0);
    check_eq("bus_be", bus_be, is_d ? dm_be : 4'b1111);
    check_eq("bus_wdata", bus_wdata, is_d ? dm_wdata : '0);
    for (int k = 0; k <= c; k++) begin
      if (k > 0) begin
        check_eq("bus_req_hold", bus_req, 1);
        check_eq("bus_addr_hold", bus_addr, is_d ? dm_addr : im_addr);
      end
      check_eq("ack_in_busy", {im_ack, dm_ack}, 2'b00);
      bus_ack   = (k == w);
      bus_rdata = (k == w) ? rd : DW'($urandom);
      step();
    end
    bus_ack = 1'b0;
    exp_rd  = (err || (is_d && dm_we)) ? '0 : rd;
    check_eq("im_ack", im_ack, !is_d);
    check_eq("dm_ack", dm_ack, is_d);
    check_eq("bus_err", bus_err, err);
    check_eq("bus_req_drop", bus_req, 0);
    if (is_d) check_eq("dm_rdata", dm_rdata, exp_rd);
    else      check_eq("im_rdata", im_rdata, exp_rd);
    mdl_last_d = is_d;
    // Stray bus_ack during DONE must be ignored; the winner's req is still held here.
    bus_ack   = ($urandom_range(0, 2) == 0);
    bus_rdata = DW'($urandom);
    step();
    bus_ack = 1'b0;
    check_eq("no_reissue", bus_req, 0);
    check_eq("ack_pulse_end", {im_ack, dm_ack, bus_err}, 3'b000);
    if (is_d) dm_req = 1'b0;
    else      im_req = 1'b0;
  endtask

  task automatic round(input bit pi, input bit pd, input int wi, input int wd,
                       input logic [DW-1:0] rdi, input logic [DW-1:0] rdd);
    bit first;
    im_req = pi;
    dm_req = pd;
    step();
    first = pick_d(pi, pd);
    serve(first, first ? wd : wi, first ? rdd : rdi);
    if (pi && pd) begin
      step();
      serve(!first, first ? wi : wd, first ? rdi : rdd);
    end
  endtask

  task automatic rand_fields();
    im_addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    dm_addr  = $urandom;
    dm_we    = $urandom_range(0, 1);
    dm_be    = 4'($urandom_range(1, 15));
    dm_wdata = $urandom;
  endtask

  initial begin
    rst_n = 1'b0; im_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    im_addr = '0; dm_addr = '0; dm_we = 1'b0; dm_be = '0; dm_wdata = '0;
    repeat (3) step();
    check_eq("rst_outputs", {bus_req, bus_we, bus_be, im_ack, dm_ack, bus_err}, '0);
    check_eq("rst_rdata", {im_rdata, dm_rdata, bus_addr, bus_wdata}, '0);
    rst_n = 1'b1;
    step();

    // Contention straight after reset: D write first, then I.
    im_addr = 32'h0000_0040; dm_addr = 32'h0000_2000; dm_we = 1'b1;
    dm_be = 4'b0011; dm_wdata = 32'hDEAD_BEEF;
    round(1, 1, 1, 1, 32'h1111_0000, 32'h5555_AAAA);
    // Next contention goes to D again by alternation.
    dm_we = 1'b0; dm_addr = 32'h0000_3000;
    round(1, 1, 0, 2, 32'h2222_0000, 32'h6666_0000);

    // IF-only read with two wait states.
    im_addr = 32'h0000_0100;
    round(1, 0, 2, 0, 32'h0000_0013, '0);

    // Zero-wait data read.
    round(0, 1, 0, 0, '0, 32'hCAFE_F00D);

    // Timeout on a data read, then a normal access.
    round(0, 1, 0, TO + 3, '0, 32'hBAD0_BAD0);
    round(0, 1, 0, 1, '0, 32'h0123_4567);

    // bus_ack in the same cycle the counter hits the limit.
    round(1, 0, TO - 1, 0, 32'h7777_8888, '0);
    round(0, 1, 0, TO - 1, '0, 32'h9999_AAAA);

    // Asynchronous reset in the middle of a data transaction.
    dm_addr = 32'h0000_4400; dm_we = 1'b0;
    dm_req = 1'b1;
    step();
    check_eq("pre_rst_bus_req", bus_req, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_bus_req", bus_req, 0);
    check_eq("async_rst_acks", {im_ack, dm_ack, bus_err}, 3'b000);
    step();
    rst_n = 1'b1;
    mdl_last_d = 1'b0;
    step();
    serve(1'b1, 1, 32'h4444_5555);

    // Randomized traffic.
    for (int r = 0; r < 150; r++) begin
      bit pi, pd;
      pi = $urandom_range(0, 1);
      pd = pi ? $urandom_range(0, 1) : 1'b1;
      rand_fields();
      round(pi, pd, $urandom_range(0, TO + 2), $urandom_range(0, TO + 2),
            DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
